// File: rtl/seg_scan_driver.sv
// Time-multiplexed seven-segment scanner with double-buffered digit data.
// Each digit is selected for REFRESH_DIV cycles, the first of which is dark to avoid ghosting.
module seg_scan_driver #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter bit SEG_ACTIVE_LOW = 1'b1,
    parameter bit AN_ACTIVE_LOW  = 1'b1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    enable,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] value_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    lz_suppress,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    frame_tick
);
    localparam int PW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IW = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [PW-1:0]         PRESC_LAST = PW'(REFRESH_DIV - 1);
    localparam logic [IW-1:0]         IDX_LAST   = IW'(NUM_DIGITS - 1);
    localparam logic [6:0]            SEG_OFF    = {7{SEG_ACTIVE_LOW}};
    localparam logic                  DP_OFF     = SEG_ACTIVE_LOW;
    localparam logic [NUM_DIGITS-1:0] AN_OFF     = {NUM_DIGITS{AN_ACTIVE_LOW}};

    typedef struct packed {
        logic [4*NUM_DIGITS-1:0] value;
        logic [NUM_DIGITS-1:0]   dp;
        logic [NUM_DIGITS-1:0]   blank;
    } frame_t;

    frame_t                  in_frame, shadow_q, shadow_d, active_q, active_d;
    logic [PW-1:0]           presc_q, presc_d;
    logic [IW-1:0]           idx_q, idx_d;
    logic                    pending_q, pending_d;
    logic                    en_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic                    tick_q, tick_d;
    logic                    presc_last, wrap, show, lz_dark, dark;
    logic [3:0]              cur_nibble;
    logic                    cur_dp, cur_blank;

    // Segment bits are {g,f,e,d,c,b,a}, active-high.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] h);
        logic [6:0] s;
        unique case (h)
            4'h0: s = 7'h3F;
            4'h1: s = 7'h06;
            4'h2: s = 7'h5B;
            4'h3: s = 7'h4F;
            4'h4: s = 7'h66;
            4'h5: s = 7'h6D;
            4'h6: s = 7'h7D;
            4'h7: s = 7'h07;
            4'h8: s = 7'h7F;
            4'h9: s = 7'h67;
            4'hA: s = 7'h77;
            4'hB: s = 7'h7C;
            4'hC: s = 7'h39;
            4'hD: s = 7'h5E;
            4'hE: s = 7'h79;
            4'hF: s = 7'h71;
        endcase
        return s;
    endfunction

    assign in_frame   = '{value: value_in, dp: dp_in, blank: blank_in};
    assign presc_last = (presc_q == PRESC_LAST);
    assign wrap       = enable && presc_last && (idx_q == IDX_LAST);
    // A digit is lit only when the previous cycle was also enabled and no index change is due.
    assign show       = enable && en_q && !presc_last;
    assign cur_nibble = 4'(active_q.value >> {idx_q, 2'b00});
    assign cur_dp     = 1'(active_q.dp >> idx_q);
    assign cur_blank  = 1'(active_q.blank >> idx_q);
    assign lz_dark    = lz_suppress && (idx_q != '0) && ((active_q.value >> {idx_q, 2'b00}) == '0);
    assign dark       = cur_blank || lz_dark;

    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    always_comb begin
        presc_d   = presc_q;
        idx_d     = idx_q;
        shadow_d  = shadow_q;
        active_d  = active_q;
        pending_d = pending_q;
        if (enable) begin
            if (presc_last) begin
                presc_d = '0;
                idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
            end else begin
                presc_d = presc_q + PW'(1);
            end
            if (wrap) begin
                if (load) begin
                    shadow_d = in_frame;
                    active_d = in_frame;
                end else if (pending_q) begin
                    active_d = shadow_q;
                end
                pending_d = 1'b0;
            end else if (load) begin
                shadow_d  = in_frame;
                pending_d = 1'b1;
            end
        end else if (load) begin
            // Display is dark while disabled, so the active frame can be replaced directly.
            shadow_d  = in_frame;
            active_d  = in_frame;
            pending_d = 1'b0;
        end
    end

    always_comb begin
        seg_d  = SEG_OFF;
        dp_d   = DP_OFF;
        an_d   = AN_OFF;
        tick_d = wrap;
        if (show) begin
            an_d = (NUM_DIGITS'(1) << idx_q) ^ AN_OFF;
            if (!dark) begin
                seg_d = hex_to_seg(cur_nibble) ^ SEG_OFF;
                dp_d  = cur_dp ^ DP_OFF;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q   <= '0;
            idx_q     <= '0;
            shadow_q  <= '0;
            active_q  <= '0;
            pending_q <= 1'b0;
            en_q      <= 1'b1;
            seg_q     <= SEG_OFF;
            dp_q      <= DP_OFF;
            an_q      <= AN_OFF;
            tick_q    <= 1'b0;
        end else begin
            presc_q   <= presc_d;
            idx_q     <= idx_d;
            shadow_q  <= shadow_d;
            active_q  <= active_d;
            pending_q <= pending_d;
            en_q      <= enable;
            seg_q     <= seg_d;
            dp_q      <= dp_d;
            an_q      <= an_d;
            tick_q    <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = tick_q;
endmodule
